// File: rtl/decision_engine_if.sv
// rtl/decision_engine_if.sv - VST access bus for decision_engine; defines VAR_NUM / VAR_NUM_LOG
`ifndef VAR_NUM
`define VAR_NUM 8
`endif
`ifndef VAR_NUM_LOG
`define VAR_NUM_LOG 3
`endif

interface decision_engine_if;
    logic                    decision_vst_en;
    logic                    decision_vst_write;
    logic [2:0]              decision_vst_address;
    logic [`VAR_NUM_LOG-1:0] decision_rewrite_free_bit;
    logic [`VAR_NUM-1:0]     decision_vst_in;
    logic [`VAR_NUM-1:0]     decision_vst_out;

    modport master (
        output decision_vst_en,
        output decision_vst_write,
        output decision_vst_address,
        output decision_rewrite_free_bit,
        output decision_vst_in,
        input  decision_vst_out
    );

    modport slave (
        input  decision_vst_en,
        input  decision_vst_write,
        input  decision_vst_address,
        input  decision_rewrite_free_bit,
        input  decision_vst_in,
        output decision_vst_out
    );
endinterface

// File: rtl/decision_engine.sv
// rtl/decision_engine.sv - picks the lowest unassigned variable, writes it to the VST, keeps a decision stack
// Optional macro PHASE_SAVE_EN: decide with the value retained in the VST instead of always positive.
`ifndef VAR_NUM
`define VAR_NUM 8
`endif
`ifndef VAR_NUM_LOG
`define VAR_NUM_LOG 3
`endif

module decision_engine (
    input  logic                    clk,
    input  logic                    rst,
    decision_engine_if.master       vst,
    input  logic                    decide_request,
    output logic                    decide_done,
    output logic                    all_assigned,
    input  logic                    pop_req,
    output logic                    pop_ack,
    output logic [`VAR_NUM_LOG-1:0] pop_var,
    output logic [3:0]              decision_level,
    output logic                    stack_overflow
);
    localparam logic [3:0] DEPTH = 4'(`VAR_NUM);

    typedef enum logic [2:0] {
        IDLE, RD_ASG, WAIT_ASG, RD_VAL, WAIT_VAL, WR_VAL, WR_ASG, DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [`VAR_NUM-1:0]     asg_reg, val_reg;
    logic [`VAR_NUM_LOG-1:0] free_idx, free_idx_nxt, top_idx;
    logic [`VAR_NUM_LOG-1:0] stack_mem [0:`VAR_NUM-1];
    logic                    asg_full, phase, push, pop_accept;
    logic [`VAR_NUM-1:0]     val_word, asg_word;

    assign asg_full   = &asg_reg;
    assign push       = (state == DONE) && !asg_full;
    assign pop_accept = (state == IDLE) && pop_req && !decide_request && (decision_level != 4'd0);
    assign top_idx    = decision_level[`VAR_NUM_LOG-1:0] - 1'b1;

`ifdef PHASE_SAVE_EN
    assign phase = val_reg[free_idx];
`else
    assign phase = 1'b1;
`endif

    // Lowest zero bit of the mask being read back this cycle
    always_comb begin
        free_idx_nxt = '0;
        for (int i = `VAR_NUM - 1; i >= 0; i--) begin
            if (!vst.decision_vst_out[i]) free_idx_nxt = i[`VAR_NUM_LOG-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (decide_request) state_nxt = RD_ASG;
            RD_ASG:   state_nxt = WAIT_ASG;
            WAIT_ASG: state_nxt = (&vst.decision_vst_out) ? DONE : RD_VAL;
            RD_VAL:   state_nxt = WAIT_VAL;
            WAIT_VAL: state_nxt = WR_VAL;
            WR_VAL:   state_nxt = WR_ASG;
            WR_ASG:   state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        val_word           = val_reg;
        val_word[free_idx] = phase;
        asg_word           = asg_reg;
        asg_word[free_idx] = 1'b1;
    end

    always_comb begin
        vst.decision_vst_en           = 1'b0;
        vst.decision_vst_write        = 1'b0;
        vst.decision_vst_address      = 3'd0;
        vst.decision_rewrite_free_bit = '0;
        vst.decision_vst_in           = '0;
        decide_done                   = 1'b0;
        all_assigned                  = 1'b0;
        case (state)
            RD_ASG: vst.decision_vst_en = 1'b1;
            RD_VAL: begin
                vst.decision_vst_en      = 1'b1;
                vst.decision_vst_address = 3'd1;
            end
            WR_VAL: begin
                vst.decision_vst_en           = 1'b1;
                vst.decision_vst_write        = 1'b1;
                vst.decision_vst_address      = 3'd1;
                vst.decision_rewrite_free_bit = free_idx;
                vst.decision_vst_in           = val_word;
            end
            WR_ASG: begin
                vst.decision_vst_en    = 1'b1;
                vst.decision_vst_write = 1'b1;
                vst.decision_vst_in    = asg_word;
            end
            DONE: begin
                decide_done  = 1'b1;
                all_assigned = asg_full;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asg_reg        <= '0;
            val_reg        <= '0;
            free_idx       <= '0;
            decision_level <= 4'd0;
            stack_overflow <= 1'b0;
            pop_ack        <= 1'b0;
            pop_var        <= '0;
        end else begin
            pop_ack <= 1'b0;
            if (state == WAIT_ASG) begin
                asg_reg  <= vst.decision_vst_out;
                free_idx <= free_idx_nxt;
            end
            if (state == WAIT_VAL) val_reg <= vst.decision_vst_out;
            // A push at full depth is lost; only the sticky flag records it
            if (push) begin
                if (decision_level == DEPTH) stack_overflow <= 1'b1;
                else                         decision_level <= decision_level + 4'd1;
            end
            if (pop_accept) begin
                pop_ack        <= 1'b1;
                pop_var        <= stack_mem[top_idx];
                decision_level <= decision_level - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && decision_level != DEPTH)
            stack_mem[decision_level[`VAR_NUM_LOG-1:0]] <= free_idx;
    end
endmodule
